// File: rtl/pingpong_pkg.sv
// Shared types and constants for the ping-pong bank read controller.
// The helper decides whether one more RAM read fits in the skid FIFO.
package pingpong_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2
    } state_e;

    localparam int unsigned DEFAULT_DATA_W = 16;
    localparam int unsigned DEFAULT_DEPTH  = 8;
    localparam int unsigned SKID_DEPTH     = 2;
    localparam int unsigned SKID_CNT_W     = 2;

    // Issue only if occupancy plus the read in flight, less this cycle's pop, leaves a free slot.
    function automatic logic can_issue(input logic [SKID_CNT_W-1:0] count,
                                       input logic                  inflight,
                                       input logic                  pop);
        return ({1'b0, count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
    endfunction

endpackage

// File: rtl/pp_skid_fifo.sv
// Two-entry FIFO of {last, data} that absorbs the one-cycle RAM read latency
// so the output stream can stall without dropping returning words.
module pp_skid_fifo
    import pingpong_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  push_i,
    input  logic [DATA_W-1:0]     push_data_i,
    input  logic                  push_last_i,
    input  logic                  pop_i,
    output logic [SKID_CNT_W-1:0] count_o,
    output logic                  head_valid_o,
    output logic [DATA_W-1:0]     head_data_o,
    output logic                  head_last_o
);

    logic [DATA_W:0]       mem_q [SKID_DEPTH];
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [SKID_CNT_W-1:0] count_q;
    logic [SKID_CNT_W-1:0] count_d;
    logic                  do_pop;

    assign do_pop = pop_i && (count_q != '0);

    always_comb begin
        count_d = count_q;
        unique case ({push_i, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= {push_last_i, push_data_i};
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    assign count_o      = count_q;
    assign head_valid_o = (count_q != '0);
    assign head_data_o  = mem_q[rd_ptr_q][DATA_W-1:0];
    assign head_last_o  = mem_q[rd_ptr_q][DATA_W];

endmodule

// File: rtl/pingpong_reader.sv
// Read side of the ping-pong operand banks: waits for the current read bank to be
// full, streams its words out through a skid FIFO, then frees it and flips banks.
module pingpong_reader
    import pingpong_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned DEPTH  = DEFAULT_DEPTH,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              wr_done_i,
    input  logic              wr_bank_i,
    output logic [1:0]        bank_free_o,
    output logic              mem_rd_en_o,
    output logic              mem_rd_bank_o,
    output logic [ADDR_W-1:0] mem_rd_addr_o,
    input  logic [DATA_W-1:0] mem_rd_data_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              out_last_o,
    output logic              rd_bank_o,
    output logic              rd_bank_n_o,
    output logic              err_o
);

    state_e                state_q;
    logic [ADDR_W-1:0]     addr_q;
    logic                  rd_bank_q;
    logic [1:0]            full_q;
    logic [1:0]            full_d;
    logic                  err_q;
    logic                  err_d;
    logic                  inflight_q;
    logic                  inflight_last_q;

    logic [SKID_CNT_W-1:0] skid_count;
    logic                  head_valid;
    logic                  head_last;
    logic [DATA_W-1:0]     head_data;

    logic                  pop;
    logic                  issue;
    logic                  issue_last;
    logic                  drain_done;

    assign pop        = head_valid && out_ready_i;
    assign issue      = (state_q == FETCH) && can_issue(skid_count, inflight_q, pop);
    assign issue_last = (addr_q == ADDR_W'(DEPTH - 1));
    assign drain_done = (state_q == FLUSH) && pop && head_last;

    // Clear before set: a refill landing on the releasing edge keeps the bank full.
    always_comb begin
        full_d = full_q;
        if (drain_done) begin
            full_d[rd_bank_q] = 1'b0;
        end
        if (wr_done_i) begin
            full_d[wr_bank_i] = 1'b1;
        end
    end

    always_comb begin
        err_d = err_q;
        if (wr_done_i && full_q[wr_bank_i] && !(drain_done && (wr_bank_i == rd_bank_q))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            rd_bank_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (full_q[rd_bank_q]) begin
                        state_q <= FETCH;
                        addr_q  <= '0;
                    end
                end
                FETCH: begin
                    if (issue) begin
                        addr_q <= addr_q + ADDR_W'(1);
                        if (issue_last) begin
                            state_q <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (drain_done) begin
                        state_q   <= IDLE;
                        rd_bank_q <= ~rd_bank_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            full_q          <= 2'b00;
            err_q           <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            full_q          <= full_d;
            err_q           <= err_d;
            inflight_q      <= issue;
            inflight_last_q <= issue && issue_last;
        end
    end

    pp_skid_fifo #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .push_i       (inflight_q),
        .push_data_i  (mem_rd_data_i),
        .push_last_i  (inflight_last_q),
        .pop_i        (pop),
        .count_o      (skid_count),
        .head_valid_o (head_valid),
        .head_data_o  (head_data),
        .head_last_o  (head_last)
    );

    assign bank_free_o   = ~full_q;
    assign mem_rd_en_o   = issue;
    assign mem_rd_bank_o = rd_bank_q;
    assign mem_rd_addr_o = addr_q;
    assign out_data_o    = head_data;
    assign out_valid_o   = head_valid;
    assign out_last_o    = head_last;
    assign rd_bank_o     = rd_bank_q;
    assign rd_bank_n_o   = ~rd_bank_q;
    assign err_o         = err_q;

endmodule
